imuldiv_div_requester: RTL and testbench

Initiator-side front end for the iterative divider. It accepts divide ops from the pipeline, drives the divider's val/rdy request port, and holds each message stable until the divider accepts it. It collects divider responses in issue order, tags them and presents quotient/remainder to writeback. Divide-by-zero ops are answered locally without reaching the divider.

---
 rtl/imuldiv_div_requester_pkg.sv | 32 +++
 rtl/imuldiv_div_tag_fifo.sv | 55 +++++
 rtl/imuldiv_div_requester.sv | 147 ++++++++++++++
 tb/tb_imuldiv_div_requester.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_requester_pkg.sv
// rtl/imuldiv_div_requester_pkg.sv - shared divide request/response encodings
package imuldiv_div_requester_pkg;

  // Divide function encodings carried on divreq_msg_fn
  localparam logic DIV_FN_DIV  = 1'b0;
  localparam logic DIV_FN_DIVU = 1'b1;

  // Divider response field slices: {remainder, quotient}
  localparam int RESULT_W = 64;
  localparam int QUOT_LSB = 0;
  localparam int QUOT_MSB = 31;
  localparam int REM_LSB  = 32;
  localparam int REM_MSB  = 63;

  // Quotient returned for a divide by zero
  localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
  } div_req_t;

  function automatic logic [31:0] result_quot(input logic [RESULT_W-1:0] r);
    return r[QUOT_MSB:QUOT_LSB];
  endfunction

  function automatic logic [31:0] result_rem(input logic [RESULT_W-1:0] r);
    return r[REM_MSB:REM_LSB];
  endfunction

endpackage

// File: rtl/imuldiv_div_tag_fifo.sv
// rtl/imuldiv_div_tag_fifo.sv - in-order tag FIFO for ops outstanding at the divider
module imuldiv_div_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = mem[rd_ptr];

  // Tag storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/imuldiv_div_requester.sv
// rtl/imuldiv_div_requester.sv - issue divide ops to the divider and return tagged results in order
module imuldiv_div_requester
  import imuldiv_div_requester_pkg::*;
#(
  parameter int TAG_W     = 5,
  parameter int DEPTH     = 4,
  parameter int DZ_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                op_val,
  output logic                op_rdy,
  input  logic                op_fn,
  input  logic [31:0]         op_a,
  input  logic [31:0]         op_b,
  input  logic [TAG_W-1:0]    op_tag,

  output logic                divreq_val,
  input  logic                divreq_rdy,
  output logic                divreq_msg_fn,
  output logic [31:0]         divreq_msg_a,
  output logic [31:0]         divreq_msg_b,

  input  logic                divresp_val,
  output logic                divresp_rdy,
  input  logic [RESULT_W-1:0] divresp_msg_result,

  output logic                wb_val,
  input  logic                wb_rdy,
  output logic [31:0]         wb_quot,
  output logic [31:0]         wb_rem,
  output logic [TAG_W-1:0]    wb_tag,

  output logic                err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  div_req_t         req_msg;
  logic             req_full;
  logic             out_full;

  logic [TAG_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic             is_dz;
  logic             normal_rdy;
  logic             dz_rdy;
  logic             op_fire;
  logic             normal_fire;
  logic             dz_fire;
  logic             req_fire;
  logic             resp_fire;
  logic             resp_load;
  logic             wb_fire;

  // A zero divisor is answered locally only when the bypass is enabled
  assign is_dz = (DZ_BYPASS != 0) && (op_b == 32'd0);

  assign req_fire  = req_full & divreq_rdy;
  assign wb_fire   = out_full & wb_rdy;
  assign resp_fire = divresp_val & divresp_rdy;
  // Responses with nothing outstanding are swallowed without touching the output
  assign resp_load = resp_fire & ~fifo_empty;

  // Occupancy is sampled before any same-cycle pop, so a full FIFO always blocks
  assign normal_rdy = (~req_full | req_fire) & ~fifo_full;
  // Bypass results must not overtake anything older, so wait for a fully drained pipe
  assign dz_rdy     = (fifo_count == '0) & ~req_full & (~out_full | wb_fire);

  assign op_rdy      = is_dz ? dz_rdy : normal_rdy;
  assign op_fire     = op_val & op_rdy;
  assign normal_fire = op_fire & ~is_dz;
  assign dz_fire     = op_fire & is_dz;

  assign divresp_rdy = ~out_full | wb_fire;

  assign divreq_val    = req_full;
  assign divreq_msg_fn = req_msg.fn;
  assign divreq_msg_a  = req_msg.a;
  assign divreq_msg_b  = req_msg.b;

  assign wb_val = out_full;

  imuldiv_div_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (normal_fire),
    .push_tag (op_tag),
    .pop      (resp_load),
    .head_tag (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Request stage: hold the message until the divider takes it, reload on back-to-back issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_full <= 1'b0;
      req_msg  <= '0;
    end else if (normal_fire) begin
      req_full <= 1'b1;
      req_msg  <= '{fn: op_fn, a: op_a, b: op_b};
    end else if (req_fire) begin
      req_full <= 1'b0;
    end
  end

  // Output stage: bypass result or divider result, held until writeback accepts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_full <= 1'b0;
      wb_quot  <= '0;
      wb_rem   <= '0;
      wb_tag   <= '0;
    end else if (dz_fire) begin
      out_full <= 1'b1;
      wb_quot  <= DZ_QUOT;
      wb_rem   <= op_a;
      wb_tag   <= op_tag;
    end else if (resp_load) begin
      out_full <= 1'b1;
      wb_quot  <= result_quot(divresp_msg_result);
      wb_rem   <= result_rem(divresp_msg_result);
      wb_tag   <= fifo_head;
    end else if (wb_fire) begin
      out_full <= 1'b0;
    end
  end

  // Sticky flag for a divider response that has no outstanding op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (divresp_val && fifo_empty) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// tb/tb_imuldiv_div_requester.sv - directed self-checking bench for imuldiv_div_requester
module tb_imuldiv_div_requester;

  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              op_val;
  logic              op_rdy;
  logic              op_fn;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [TAG_W-1:0]  op_tag;
  logic              divreq_val;
  logic              divreq_rdy;
  logic              divreq_msg_fn;
  logic [31:0]       divreq_msg_a;
  logic [31:0]       divreq_msg_b;
  logic              divresp_val;
  logic              divresp_rdy;
  logic [63:0]       divresp_msg_result;
  logic              wb_val;
  logic              wb_rdy;
  logic [31:0]       wb_quot;
  logic [31:0]       wb_rem;
  logic [TAG_W-1:0]  wb_tag;
  logic              err;

  int total = 0;
  int bad   = 0;

  imuldiv_div_requester #(
    .TAG_W     (TAG_W),
    .DEPTH     (4),
    .DZ_BYPASS (1)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .op_val             (op_val),
    .op_rdy             (op_rdy),
    .op_fn              (op_fn),
    .op_a               (op_a),
    .op_b               (op_b),
    .op_tag             (op_tag),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy),
    .divresp_msg_result (divresp_msg_result),
    .wb_val             (wb_val),
    .wb_rdy             (wb_rdy),
    .wb_quot            (wb_quot),
    .wb_rem             (wb_rem),
    .wb_tag             (wb_tag),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] credit_res(input int t);
    return {32'(t), 32'(100 + t)};
  endfunction

  initial begin
    reset_n            = 1'b0;
    op_val             = 1'b0;
    op_fn              = 1'b0;
    op_a               = '0;
    op_b               = 32'd1;
    op_tag             = '0;
    divreq_rdy         = 1'b0;
    divresp_val        = 1'b0;
    divresp_msg_result = '0;
    wb_rdy             = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_divreq_val", divreq_val, 0);
    chk("rst_wb_val", wb_val, 0);
    chk("rst_divresp_rdy", divresp_rdy, 1);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_op_rdy", op_rdy, 1);

    // single op: DIV 100/7 tag 3
    divreq_rdy = 1'b1;
    op_val = 1'b1; op_fn = 1'b0; op_a = 32'd100; op_b = 32'd7; op_tag = 5'd3;
    settle();
    chk("s_op_rdy", op_rdy, 1);
    tick();
    op_val = 1'b0;
    chk("s_divreq_val", divreq_val, 1);
    chk("s_msg_a", divreq_msg_a, 100);
    chk("s_msg_b", divreq_msg_b, 7);
    chk("s_msg_fn", divreq_msg_fn, 0);
    tick();
    chk("s_divreq_val_clr", divreq_val, 0);
    repeat (32) tick();
    divresp_val = 1'b1; divresp_msg_result = {32'd2, 32'd14};
    settle();
    chk("s_divresp_rdy", divresp_rdy, 1);
    chk("s_wb_val_early", wb_val, 0);
    tick();
    divresp_val = 1'b0;
    chk("s_wb_val", wb_val, 1);
    chk("s_wb_quot", wb_quot, 14);
    chk("s_wb_rem", wb_rem, 2);
    chk("s_wb_tag", wb_tag, 3);
    wb_rdy = 1'b1;
    tick();
    chk("s_wb_val_clr", wb_val, 0);
    wb_rdy = 1'b0;

    // backpressure on the request port
    divreq_rdy = 1'b0;
    op_val = 1'b1; op_fn = 1'b0; op_a = 32'hFFFF_FFEC; op_b = 32'd3; op_tag = 5'd7;
    tick();
    op_a = 32'd50; op_b = 32'd5; op_tag = 5'd8; op_fn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_divreq_val", divreq_val, 1);
      chk("bp_msg_a", divreq_msg_a, 64'hFFFF_FFEC);
      chk("bp_msg_b", divreq_msg_b, 3);
      chk("bp_msg_fn", divreq_msg_fn, 0);
      chk("bp_op_rdy_blocked", op_rdy, 0);
      tick();
    end
    divreq_rdy = 1'b1;
    settle();
    chk("bp_op_rdy_b2b", op_rdy, 1);
    tick();
    op_val = 1'b0;
    chk("bp_b2b_val", divreq_val, 1);
    chk("bp_b2b_a", divreq_msg_a, 50);
    chk("bp_b2b_fn", divreq_msg_fn, 1);
    tick();
    divreq_rdy = 1'b0;
    chk("bp_req_drained", divreq_val, 0);

    // backpressure on writeback
    divresp_val = 1'b1; divresp_msg_result = {32'hFFFF_FFFE, 32'hFFFF_FFFA};
    tick();
    divresp_msg_result = {32'd0, 32'd10};
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_wb_val", wb_val, 1);
      chk("bp_wb_quot", wb_quot, 64'hFFFF_FFFA);
      chk("bp_wb_rem", wb_rem, 64'hFFFF_FFFE);
      chk("bp_wb_tag", wb_tag, 7);
      chk("bp_divresp_rdy_blocked", divresp_rdy, 0);
      tick();
    end
    wb_rdy = 1'b1;
    settle();
    chk("bp_divresp_rdy_open", divresp_rdy, 1);
    tick();
    divresp_val = 1'b0;
    chk("bp_reload_val", wb_val, 1);
    chk("bp_reload_quot", wb_quot, 10);
    chk("bp_reload_rem", wb_rem, 0);
    chk("bp_reload_tag", wb_tag, 8);
    tick();
    chk("bp_wb_val_clr", wb_val, 0);

    // credit limit: tags 1..6 against a slow divider
    divreq_rdy = 1'b1;
    wb_rdy = 1'b0;
    op_fn = 1'b0; op_b = 32'd3;
    for (int t = 1; t <= 4; t++) begin
      op_val = 1'b1; op_a = 32'(t * 10); op_tag = 5'(t);
      settle();
      chk("cr_op_rdy_accept", op_rdy, 1);
      tick();
    end
    op_a = 32'd50; op_tag = 5'd5;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("cr_op_rdy_full", op_rdy, 0);
      tick();
    end
    wb_rdy = 1'b1;
    divresp_val = 1'b1; divresp_msg_result = credit_res(1);
    settle();
    chk("cr_op_rdy_pop_pending", op_rdy, 0);
    tick();
    divresp_val = 1'b0;
    settle();
    chk("cr_wb_tag1", wb_tag, 1);
    chk("cr_op_rdy_rise", op_rdy, 1);
    tick();
    op_a = 32'd60; op_tag = 5'd6;
    settle();
    chk("cr_op_rdy_full2", op_rdy, 0);
    divresp_val = 1'b1; divresp_msg_result = credit_res(2);
    tick();
    chk("cr_wb_tag2", wb_tag, 2);
    chk("cr_op_rdy_tag6", op_rdy, 1);
    divresp_msg_result = credit_res(3);
    tick();
    op_val = 1'b0;
    chk("cr_wb_tag3", wb_tag, 3);
    chk("cr_wb_quot3", wb_quot, 103);
    for (int t = 4; t <= 6; t++) begin
      divresp_msg_result = credit_res(t);
      tick();
      chk("cr_wb_val", wb_val, 1);
      chk("cr_wb_tag", wb_tag, 64'(t));
      chk("cr_wb_quot", wb_quot, 64'(100 + t));
      chk("cr_wb_rem", wb_rem, 64'(t));
    end
    divresp_val = 1'b0;
    tick();
    chk("cr_wb_val_clr", wb_val, 0);

    // divide by zero behind two outstanding ops
    op_val = 1'b1; op_fn = 1'b0; op_a = 32'd9; op_b = 32'd4; op_tag = 5'd11;
    tick();
    op_tag = 5'd12;
    tick();
    op_fn = 1'b1; op_a = 32'h1234; op_b = 32'd0; op_tag = 5'd9;
    settle();
    chk("dz_op_rdy_wait", op_rdy, 0);
    tick();
    chk("dz_no_divreq", divreq_val, 0);
    divresp_val = 1'b1; divresp_msg_result = {32'd1, 32'd2};
    tick();
    chk("dz_wb_tag11", wb_tag, 11);
    chk("dz_op_rdy_wait2", op_rdy, 0);
    divresp_msg_result = {32'd1, 32'd2};
    tick();
    divresp_val = 1'b0;
    settle();
    chk("dz_wb_tag12", wb_tag, 12);
    chk("dz_op_rdy_go", op_rdy, 1);
    tick();
    op_val = 1'b0;
    chk("dz_wb_val", wb_val, 1);
    chk("dz_wb_quot", wb_quot, 64'hFFFF_FFFF);
    chk("dz_wb_rem", wb_rem, 64'h1234);
    chk("dz_wb_tag", wb_tag, 9);
    chk("dz_no_divreq2", divreq_val, 0);
    tick();
    chk("dz_wb_val_clr", wb_val, 0);

    // protocol error: response with nothing outstanding
    divresp_val = 1'b1; divresp_msg_result = {32'd5, 32'd6};
    settle();
    chk("er_divresp_rdy", divresp_rdy, 1);
    tick();
    divresp_val = 1'b0;
    chk("er_err", err, 1);
    chk("er_wb_val", wb_val, 0);
    tick();
    chk("er_err_sticky", err, 1);

    // asynchronous reset with work in flight
    wb_rdy = 1'b0; divreq_rdy = 1'b0;
    op_val = 1'b1; op_fn = 1'b1; op_a = 32'd77; op_b = 32'd0; op_tag = 5'd2;
    tick();
    op_fn = 1'b0; op_b = 32'd3; op_tag = 5'd4;
    tick();
    op_val = 1'b0;
    chk("ar_pre_wb_val", wb_val, 1);
    chk("ar_pre_divreq_val", divreq_val, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_divreq_val", divreq_val, 0);
    chk("ar_wb_val", wb_val, 0);
    chk("ar_err", err, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_op_rdy", op_rdy, 1);
    chk("ar_divreq_val_post", divreq_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
